bram_port_arbiter: RTL
======================

# bram_port_arbiter

Round-robin arbiter that shares one port of `dual_port_BRAM` among `NUM_REQ` requesters, such as core fetch, core data and a debug or loader master. It sits between the requesters and the BRAM port and issues at most one read or write per cycle. It returns read data, tagged one-hot to the issuing requester, on the cycle after issue, which matches the BRAM's registered read.

## Interface
- `NUM_REQ`, 4: number of requesters; range 2–8.
- `DATA_WIDTH`, 32: BRAM word width.
- `ADDR_WIDTH`, 8: BRAM address width.
- `clock` input 1: single clock; all state changes on posedge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: per-requester request valid.
- `req_write` input NUM_REQ: 1 = write, 0 = read.
- `req_address` input NUM_REQ*ADDR_WIDTH: packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_writeData` input NUM_REQ*DATA_WIDTH: packed write data.
- `req_lock` input NUM_REQ: hold the grant for a burst; present only with `BRAM_ARB_LOCK_EN`.
- `req_ready` output NUM_REQ: one-hot grant; the request is accepted in this cycle.
- `resp_valid` output NUM_REQ: one-hot read-response valid.
- `resp_readData` output DATA_WIDTH: read data, qualified by `resp_valid`.
- `readEnable` output 1: to BRAM port `readEnable`.
- `writeEnable` output 1: to BRAM port `writeEnable`.
- `address` output ADDR_WIDTH: to BRAM port `address`.
- `writeData` output DATA_WIDTH: to BRAM port `writeData`.
- `readData` input DATA_WIDTH: from BRAM port `readData`.

## Operation
- **Grant selection.** The grant is combinational from `req_valid`, searched upward from priority pointer `ptr` with wrap-around; the lowest index at or after `ptr` wins.
- **Handshake.** A transfer occurs when `req_valid[i]` and `req_ready[i]` are both 1.
  - The requester holds valid and its payload stable until ready.
  - `req_ready` is never 1 for an idle requester.
- **BRAM drive.** While a request is granted:
  - `address` and `writeData` come from the granted requester.
  - `writeEnable = req_write[g]`; `readEnable = ~req_write[g]`.
- **Idle.** With no valid request, all BRAM strobes are 0; address and data are held at 0.
- **Pointer update.** After any grant g, `ptr <= (g+1) mod NUM_REQ`. With no grant, `ptr` holds.
- **Response tracking.** Register `rd_tag_q` (one-hot) captures the read grant.
  - Next cycle `resp_valid = rd_tag_q` and `resp_readData = readData`.
  - Writes produce no response.
- **Simultaneous events.** A new grant and the response for the previous read coexist in the same cycle. Full throughput is one transfer per cycle.
- **Other BRAM port.** It is not controlled by this block. Same-address collisions there follow BRAM semantics.

## Timing
- Grant latency: 0 cycles (same cycle as valid).
- Read latency: 1 cycle, from accept edge to `resp_valid`.
- Reset values:
  - `req_ready = 0`, `resp_valid = 0`, `resp_readData = 0`.
  - All BRAM strobes, `address` and `writeData` = 0.
  - `ptr = 0`, `rd_tag_q = 0`, lock state = UNLOCKED.
- Reset asserted mid-operation:
  - A pending read response is dropped and `resp_valid` is forced to 0 asynchronously.
  - Requesters must reissue after reset.
- `NUM_REQ` not a power of two: `ptr` wraps explicitly at `NUM_REQ-1`.

## Configuration
- Macro `BRAM_ARB_LOCK_EN`.
- **Defined:** the `req_lock` port exists, and a 2-state FSM is added.
  - UNLOCKED → LOCKED when the granted requester has `req_lock[g]=1` at accept; `owner <= g`.
  - In LOCKED only `owner` can be granted. `ptr` is frozen.
  - LOCKED → UNLOCKED on an accepted transfer with `req_lock[owner]=0`. Then `ptr <= owner+1`.
  - An idle owner while LOCKED stalls all other requesters; no timeout.
- **Undefined:** the `req_lock` port is absent, with no FSM and pure round-robin.

## Structure
- Package `bram_arb_pkg` holds:
  - the lock state enum, UNLOCKED=0 and LOCKED=1;
  - the `MAX_REQ = 8` constant;
  - the one-hot-to-index function.
- Sub-module `rr_priority_picker`, parameter N, ports `req[N]` and `ptr`; outputs `grant_onehot[N]` and `grant_idx`. It is purely combinational and reusable.

## Test plan
1. **Single write then read.** Requester 0 writes 0x0A to address 3, then reads address 3. Expect `req_ready[0]=1` each cycle and `writeEnable` on the first cycle. Expect `resp_valid=4'b0001` with data 0x0A on the cycle after the read.
2. **All requesters valid, reads continuously for 8 cycles.** Expect grants 0,1,2,3,0,1,2,3. Expect responses lagging one cycle with matching one-hot tags.
3. **Back-to-back mix.** Requester 1 reads address 5 (preloaded 0x55) and requester 2 writes address 6 in the next cycle. Expect `resp_valid[1]` and the requester 2 grant in the same cycle, and no response for the write.
4. **Reset mid-read.** Assert reset in the cycle after a read accept. Expect `resp_valid=0` immediately. After release, all requesters valid: expect the first grant to go to requester 0.
5. **Lock (`BRAM_ARB_LOCK_EN`).** Requester 2 locks for 3 transfers while requesters 0 and 3 are valid. Expect grants 2,2,2, then 3, then 0. Expect `req_ready[0]=req_ready[3]=0` throughout the lock.
6. **Non-power-of-two `NUM_REQ=3`, all valid.** Expect grants 0,1,2,0 and `ptr` never equal to 3.

Source files
------------

// File: rtl/bram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_arb_pkg
// Description : Shared types, constants and helpers for the BRAM port
//               arbiter: lock state encoding, maximum requester count and
//               a one-hot to binary index converter.
// Optional    : BRAM_ARB_LOCK_EN (lock_state_e is only used when defined)
// Revision    : 1.0 - initial release
// ============================================================================
package bram_arb_pkg;

  // Largest requester count the arbiter is built for.
  localparam int MAX_REQ = 8;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Converts a one-hot vector (up to MAX_REQ bits) to its bit index.
  // An all-zero vector maps to index 0.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) begin
        idx = idx | 3'(i);
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Purely combinational round-robin picker. Searches req
//               upward from ptr with wrap-around; the first asserted
//               request at or after ptr wins.
// Ports       : req          [N]          - request vector
//               ptr          [clog2(N)]   - starting search index
//               grant_onehot [N]          - one-hot winner (0 if none)
//               grant_idx    [clog2(N)]   - winner index (0 if none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker
  import bram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant_onehot,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  always_comb begin
    int  j;
    logic found;
    j            = 0;
    found        = 1'b0;
    grant_onehot = '0;
    for (int k = 0; k < N; k++) begin
      // Modulo keeps the wrap correct even for ptr codes >= N when N is
      // not a power of two.
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        grant_onehot[j] = 1'b1;
        found           = 1'b1;
      end
    end
    grant_idx = IW'(onehot_to_idx(MAX_REQ'(grant_onehot)));
  end

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Round-robin arbiter sharing one port of a dual-port BRAM
//               among NUM_REQ requesters. At most one access per cycle,
//               grant is combinational, read data returns one cycle after
//               issue tagged one-hot with the issuing requester.
// Optional    : BRAM_ARB_LOCK_EN - adds req_lock port and a lock FSM that
//               holds the grant on one requester for a burst.
// Ports       : clock, reset (async, active-low)
//               req_valid/req_write/req_address/req_writeData - requesters
//               req_lock      - burst lock (BRAM_ARB_LOCK_EN only)
//               req_ready     - one-hot grant / accept
//               resp_valid, resp_readData - one-hot tagged read response
//               readEnable, writeEnable, address, writeData, readData
//                             - BRAM port
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_writeData,
`ifdef BRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_readData,
  output logic                          readEnable,
  output logic                          writeEnable,
  output logic [ADDR_WIDTH-1:0]         address,
  output logic [DATA_WIDTH-1:0]         writeData,
  input  logic [DATA_WIDTH-1:0]         readData
);

  localparam int               PTR_W    = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rd_tag_q, rd_tag_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic               ptr_advance;
  logic [PTR_W-1:0]   ptr_next_idx;

  rr_priority_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req          (req_valid),
    .ptr          (ptr_q),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx)
  );

`ifdef BRAM_ARB_LOCK_EN
  lock_state_e      lock_state_q, lock_state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic             lock_release;

  // While locked, only the owner may be granted, regardless of the picker.
  // Grants are suppressed while reset is asserted so no strobe escapes.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    if (lock_state_q == LOCKED) begin
      grant_idx              = owner_q;
      grant_onehot[owner_q]  = req_valid[owner_q];
    end else begin
      grant_onehot = pick_onehot;
      grant_idx    = pick_idx;
    end
    if (!reset) begin
      grant_onehot = '0;
    end
  end

  always_comb begin
    lock_state_d = lock_state_q;
    owner_d      = owner_q;
    lock_release = 1'b0;
    case (lock_state_q)
      UNLOCKED: begin
        if (grant_any && req_lock[grant_idx]) begin
          lock_state_d = LOCKED;
          owner_d      = grant_idx;
        end
      end
      LOCKED: begin
        if (grant_any && !req_lock[owner_q]) begin
          lock_state_d = UNLOCKED;
          lock_release = 1'b1;
        end
      end
      default: lock_state_d = UNLOCKED;
    endcase
  end

  // ptr is frozen during a lock; on release grant_idx equals the owner,
  // so the normal advance gives owner+1.
  always_comb begin
    ptr_advance = grant_any && ((lock_state_q == UNLOCKED) || lock_release);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_state_q <= UNLOCKED;
      owner_q      <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      owner_q      <= owner_d;
    end
  end
`else
  always_comb begin
    grant_onehot = reset ? pick_onehot : '0;
    grant_idx    = pick_idx;
    ptr_advance  = grant_any;
  end
`endif

  assign grant_any = |grant_onehot;
  assign req_ready = grant_onehot;

  // BRAM port drive: granted requester's payload, all zero when idle.
  always_comb begin
    address     = '0;
    writeData   = '0;
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    if (grant_any) begin
      address     = req_address[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      writeData   = req_writeData[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      writeEnable = req_write[grant_idx];
      readEnable  = ~req_write[grant_idx];
    end
  end

  // Explicit wrap so non-power-of-two counts never reach an unused code.
  always_comb begin
    ptr_next_idx = (grant_idx >= LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
    ptr_d        = ptr_advance ? ptr_next_idx : ptr_q;
    rd_tag_d     = readEnable ? grant_onehot : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q    <= '0;
      rd_tag_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rd_tag_q <= rd_tag_d;
    end
  end

  // The BRAM's registered read lines up with rd_tag_q; data is zeroed
  // when no response is pending so the bus is clean at reset and idle.
  assign resp_valid    = rd_tag_q;
  assign resp_readData = (|rd_tag_q) ? readData : '0;

endmodule
`default_nettype wire
